// File: rtl/rom_writer.sv
// Program-memory loader: range-checks a run, then streams words from a valid/ready
// input into consecutive memory addresses starting at a programmed address.
module rom_writer #(
  parameter int ROM_DEPTH  = 8,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic                  start_i,
  input  logic [31:0]           start_addr_i,
  input  logic [31:0]           word_count_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           wr_count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           remaining;
  logic [32:0]           end_addr;
  logic                  range_err;

  // 33-bit sum so a huge word count cannot wrap past the depth check
  assign end_addr  = {1'b0, start_addr_i} + {1'b0, word_count_i};
  assign range_err = (start_addr_i >= 32'(ROM_DEPTH)) || (end_addr > 33'(ROM_DEPTH));

  assign s_ready_o  = (state == WRITE);
  assign busy_o     = (state != IDLE);
  assign mem_addr_o = {{(32-ADDR_WIDTH){1'b0}}, mem_addr};

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state      <= IDLE;
      addr       <= '0;
      mem_addr   <= '0;
      remaining  <= '0;
      mem_we_o   <= 1'b0;
      mem_data_o <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      wr_count_o <= '0;
    end else begin
      mem_we_o <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (range_err) begin
              err_o <= 1'b1;
            end else if (word_count_i == 32'd0) begin
              wr_count_o <= '0;
              done_o     <= 1'b1;
              state      <= DONE;
            end else begin
              addr       <= start_addr_i[ADDR_WIDTH-1:0];
              remaining  <= word_count_i;
              wr_count_o <= '0;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          // Abort wins over a same-cycle handshake: that word is dropped
          if (abort_i) begin
            state <= IDLE;
          end else if (s_valid_i) begin
            mem_we_o   <= 1'b1;
            mem_addr   <= addr;
            mem_data_o <= s_data_i;
            addr       <= addr + 1'b1;
            remaining  <= remaining - 32'd1;
            wr_count_o <= wr_count_o + 32'd1;
            if (remaining == 32'd1) begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_writer.md
# rom_writer

Program loader for the bus sequencer's instruction ROM/RAM. It accepts a run of instruction words on a valid/ready stream and writes them into consecutive memory addresses from a programmed start address. It range-checks the run against the memory depth before accepting any data. It sits between the configuration/host interface and the program memory write port; `rom_reader` reads the same memory.

## Interface
- `ROM_DEPTH`, 8: words in program memory; ADDR_WIDTH = $clog2(ROM_DEPTH).
- `DATA_WIDTH`, 32: instruction word width.

- `clk_i` in 1: single clock; all logic on rising edge.
- `nrst_i` in 1: reset, asynchronous active-low.
- `start_i` in 1: one-cycle load request; sampled only in IDLE.
- `start_addr_i` in 32: first write address, sampled with `start_i`.
- `word_count_i` in 32: number of words to write, sampled with `start_i`.
- `abort_i` in 1: cancels a run in WRITE.
- `s_data_i` in DATA_WIDTH: instruction word.
- `s_valid_i` in 1: `s_data_i` valid.
- `s_ready_o` out 1: writer accepts a word.
- `mem_we_o` out 1: memory write strobe.
- `mem_addr_o` out 32: write address; bits [31:ADDR_WIDTH] always 0.
- `mem_data_o` out DATA_WIDTH: write data.
- `busy_o` out 1: high in WRITE and DONE.
- `done_o` out 1: one-cycle pulse when a run completes.
- `err_o` out 1: one-cycle pulse when a start request is rejected.
- `wr_count_o` out 32: words written in the current or last run.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: `s_ready_o`=0. On `start_i`:
  - Error if `start_addr_i >= ROM_DEPTH` or `start_addr_i + word_count_i > ROM_DEPTH`. The sum is computed 33-bit with no wrap. Result: `err_o` pulses, state stays IDLE, `wr_count_o` is unchanged.
  - Else if `word_count_i == 0`: go to DONE, with `wr_count_o` cleared to 0.
  - Else: load the address counter with `start_addr_i[ADDR_WIDTH-1:0]`, load the remaining counter with `word_count_i`, clear `wr_count_o`, and go to WRITE.
- WRITE: `s_ready_o`=1.
  - A handshake is `s_valid_i & s_ready_o`.
  - Each handshake registers one write at the address counter, then increments the address counter, decrements the remaining counter and increments `wr_count_o`.
  - The handshake that brings the remaining count to 0 moves the state to DONE. `s_ready_o` is 0 from the next cycle.
  - The address never wraps: the range check guarantees the last address is ROM_DEPTH-1 or lower.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `abort_i` in WRITE has priority over a same-cycle handshake:
  - That word is not written.
  - Next state is IDLE, with no `done_o` and no `err_o`.
  - `wr_count_o` holds the number of words written.
- `start_i` outside IDLE is ignored and produces no `err_o`.
- `abort_i` outside WRITE is ignored.

## Timing
- Reset values: state IDLE; `s_ready_o`, `mem_we_o`, `busy_o`, `done_o`, `err_o` = 0; `mem_addr_o`, `mem_data_o`, `wr_count_o` = 0.
- Reset mid-run returns the block to IDLE immediately; no further writes are issued.
- `mem_we_o`, `mem_addr_o` and `mem_data_o` are registered. For a handshake in cycle N, `mem_we_o` is high in cycle N+1 only, with that word's address and data.
- `err_o` pulses in cycle N+1 after `start_i` in cycle N.
- For a zero-length run, `done_o` pulses in cycle N+1.
- For a normal run, if the last handshake is in cycle N: the last `mem_we_o` and `done_o` are both high in cycle N+1, and `busy_o` is low from N+2.
- Full-rate throughput is one word per cycle while `s_valid_i` is held high.
- `s_ready_o` depends only on state (no combinational path from `s_valid_i`).
- `busy_o` rises the cycle after an accepted `start_i`.

## Test plan
- ROM_DEPTH=8, start_addr=2, count=4, continuous valid, data 0xA0..0xA3:
  - `mem_we_o` high 4 consecutive cycles with addr 2,3,4,5 and matching data.
  - `done_o` coincides with the addr-5 write.
  - `wr_count_o`=4.
- Same run with `s_valid_i` toggling every other cycle: the same 4 writes occur in order, with gaps, and no duplicates.
- start_addr=6, count=3 → `err_o` pulse next cycle, no `mem_we_o`, `s_ready_o` stays 0. Repeat with start_addr=8, count=0 → `err_o`.
- start_addr=0, count=8: writes at addr 0..7 then `done_o`. Then start_addr=3, count=0: `done_o` next cycle, no writes, `wr_count_o`=0.
- Abort: count=5; assert `abort_i` together with the 3rd handshake → exactly 2 writes, no `done_o`, `wr_count_o`=2. `start_i` during the run is ignored.
- Reset mid-run: drop `nrst_i` after 2 writes of a 6-word run → all outputs 0 immediately. After release, a new start_addr=1, count=1 run writes addr 1 and pulses `done_o`.
